mult_fu: RTL and testbench
==========================

Name: mult_fu

Overview:
- Pipelined integer multiply functional unit in the execute stage.
- Sits directly downstream of the issue stage: it consumes issued MUL-class instructions and presents completed results to the CDB arbiter.
- Tracks each in-flight instruction's destination physical tag and branch mask.
- Squashes wrong-path work on branch mispredict and clears resolved bits on correct prediction.

Parameters:
- XLEN, 32, operand/result width.
- NUM_STAGES, 4, pipeline depth. Must divide 2*XLEN.
- PRF_IDX_W, 6, physical register tag width.
- BMASK_W, 4, branch mask width (one bit per outstanding branch).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- is_valid  in  1  issue presents a multiply this cycle.
- is_opa  in  XLEN  operand A (rs1 value).
- is_opb  in  XLEN  operand B (rs2 value).
- is_func  in  2  0=MUL, 1=MULH, 2=MULHSU, 3=MULHU.
- is_dest_tag  in  PRF_IDX_W  destination physical register.
- is_bmask  in  BMASK_W  branch mask of the instruction.
- br_valid  in  1  a branch resolves this cycle.
- br_mask  in  BMASK_W  one-hot bit of the resolving branch.
- br_mispredict  in  1  the resolving branch mispredicted.
- cdb_grant  in  1  arbiter accepts done_* this cycle.
- fu_ready  out  1  unit accepts is_valid this cycle.
- done_valid  out  1  completed result available / CDB request.
- done_result  out  XLEN  selected product bits.
- done_tag  out  PRF_IDX_W  destination tag.
- done_bmask  out  BMASK_W  current branch mask of the result.

Behaviour:
- Reset (synchronous): all stage valid bits 0; all stage payload registers 0. While reset is high and the cycle after, done_valid=0, done_result=0, done_tag=0, done_bmask=0, fu_ready=1. Reset mid-operation discards all in-flight work; nothing appears on done_*.
- Datapath: operands are extended to 2*XLEN per is_func.
  - MUL, MULHU: both unsigned.
  - MULH: both signed.
  - MULHSU: A signed, B unsigned.
  - Each stage adds one partial product covering 2*XLEN/NUM_STAGES multiplier bits to a 2*XLEN accumulator, shifting the multiplicand accordingly.
  - Final stage output: MUL selects product[XLEN-1:0]; all other functions select product[2*XLEN-1:XLEN]. Arithmetic is modulo 2^(2*XLEN).
- Stall: stall = done_valid & ~cdb_grant.
  - On stall the whole pipeline holds; no stage advances or accepts.
  - fu_ready = ~stall, which is combinational from cdb_grant.
  - Issue must only assert is_valid when fu_ready=1. If is_valid=1 and fu_ready=0, the input is ignored.
- Latency: an instruction accepted at clock edge t asserts done_valid after edge t+NUM_STAGES-1, i.e. NUM_STAGES cycles from issue with no stall.
  - Throughput is 1 per cycle.
  - done_* holds stable while stalled.
  - Dequeue occurs at an edge where done_valid & cdb_grant.
- Branch resolve applies to every stage register and to the accepting input in the same cycle.
  - Correct prediction (br_valid & ~br_mispredict): clear the br_mask bit in every bmask, including stalled entries and the incoming is_bmask before it is stored.
  - Mispredict (br_valid & br_mispredict): any entry with (bmask & br_mask)!=0 has its valid cleared at the edge. An incoming instruction with that bit is not accepted.
  - The final-stage entry's done_valid is masked combinationally in that cycle. A squashed result never asserts done_valid, and its grant is ignored.
  - Squash bubbles are ordinary bubbles; they do not change the stall rule.
- Simultaneous events:
  - A grant and a squash of the final stage in the same cycle: the squash wins.
  - A stall with a branch resolve: masks still update and valids still clear while the payload holds.
- done_bmask always reflects masks already cleared by prior resolves.
- No X on outputs when done_valid=0: payload registers are retained from the last occupant or are 0 after reset.

Test Plan:
1. Reset, then issue MUL opa=7 opb=6 tag=5 bmask=0 with cdb_grant=1 -> done_valid=1 exactly 4 cycles later with result=42 and tag=5; done_valid=0 the following cycle.
2. MULH opa=0xFFFFFFFD (-3), opb=2 -> result 0xFFFFFFFF. MULHU with the same operands -> 0x00000001. MULHSU opa=0xFFFFFFFF, opb=0xFFFFFFFF -> 0xFFFFFFFF.
3. Issue 4 back-to-back MULs (tags 1-4, results i*3) with cdb_grant=1 -> four consecutive done cycles, in order, with no gaps.
4. Fill the pipe, hold cdb_grant=0 for 3 cycles -> fu_ready=0 and done_* stable (tag 1). Raise grant -> tags 1..4 drain one per cycle.
5. Issue tags 1 (bmask=0001), 2 (0010), 3 (0001); mispredict with br_mask=0001 while all are in flight -> only tag 2 completes. Correct resolve of 0010 instead -> all three complete, with tag 2 showing done_bmask=0000.
6. Issue 3 MULs, assert reset for 1 cycle mid-flight -> no done_valid for the next 5 cycles; a new MUL issued afterwards completes normally.

Source files
------------

// File: rtl/mult_fu.sv
// Pipelined integer multiply unit: one partial product per stage,
// tracking destination tag and branch mask for squash/resolve.
module mult_fu #(
    parameter int XLEN       = 32,
    parameter int NUM_STAGES = 4,
    parameter int PRF_IDX_W  = 6,
    parameter int BMASK_W    = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 is_valid,
    input  logic [XLEN-1:0]      is_opa,
    input  logic [XLEN-1:0]      is_opb,
    input  logic [1:0]           is_func,
    input  logic [PRF_IDX_W-1:0] is_dest_tag,
    input  logic [BMASK_W-1:0]   is_bmask,
    input  logic                 br_valid,
    input  logic [BMASK_W-1:0]   br_mask,
    input  logic                 br_mispredict,
    input  logic                 cdb_grant,
    output logic                 fu_ready,
    output logic                 done_valid,
    output logic [XLEN-1:0]      done_result,
    output logic [PRF_IDX_W-1:0] done_tag,
    output logic [BMASK_W-1:0]   done_bmask
);

    localparam int PW = 2 * XLEN;
    localparam int CW = PW / NUM_STAGES;
    localparam int L  = NUM_STAGES - 1;

    logic [NUM_STAGES-1:0] v;
    logic [PW-1:0]         acc    [NUM_STAGES];
    logic [PW-1:0]         mcand  [NUM_STAGES];
    logic [PW-1:0]         mplier [NUM_STAGES];
    logic [1:0]            func   [NUM_STAGES];
    logic [PRF_IDX_W-1:0]  tag    [NUM_STAGES];
    logic [BMASK_W-1:0]    bmask  [NUM_STAGES];

    logic [NUM_STAGES-1:0] s_v;
    logic [NUM_STAGES-1:0] n_v;
    logic [PW-1:0]         s_acc    [NUM_STAGES];
    logic [PW-1:0]         s_mcand  [NUM_STAGES];
    logic [PW-1:0]         s_mplier [NUM_STAGES];
    logic [1:0]            s_func   [NUM_STAGES];
    logic [PRF_IDX_W-1:0]  s_tag    [NUM_STAGES];
    logic [BMASK_W-1:0]    s_bm     [NUM_STAGES];
    logic [PW-1:0]         n_acc    [NUM_STAGES];
    logic [PW-1:0]         n_mcand  [NUM_STAGES];
    logic [PW-1:0]         n_mplier [NUM_STAGES];
    logic [BMASK_W-1:0]    n_bm     [NUM_STAGES];

    logic          res_ok;
    logic          res_bad;
    logic          a_sgn;
    logic          b_sgn;
    logic [PW-1:0] a_ext;
    logic [PW-1:0] b_ext;
    logic          stall;

    function automatic logic [BMASK_W-1:0] clr_mask(
        input logic [BMASK_W-1:0] m,
        input logic               ok,
        input logic [BMASK_W-1:0] bm
    );
        return ok ? (m & ~bm) : m;
    endfunction

    function automatic logic killed(
        input logic [BMASK_W-1:0] m,
        input logic               bad,
        input logic [BMASK_W-1:0] bm
    );
        return bad && (|(m & bm));
    endfunction

    assign res_ok  = br_valid & ~br_mispredict;
    assign res_bad = br_valid & br_mispredict;

    // MULH and MULHSU treat A as signed; only MULH treats B as signed
    assign a_sgn = (is_func == 2'd1) || (is_func == 2'd2);
    assign b_sgn = (is_func == 2'd1);
    assign a_ext = {{XLEN{a_sgn & is_opa[XLEN-1]}}, is_opa};
    assign b_ext = {{XLEN{b_sgn & is_opb[XLEN-1]}}, is_opb};

    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_in
            assign s_v[gi]      = is_valid;
            assign s_acc[gi]    = '0;
            assign s_mcand[gi]  = a_ext;
            assign s_mplier[gi] = b_ext;
            assign s_func[gi]   = is_func;
            assign s_tag[gi]    = is_dest_tag;
            assign s_bm[gi]     = is_bmask;
        end else begin : g_pipe
            assign s_v[gi]      = v[gi-1];
            assign s_acc[gi]    = acc[gi-1];
            assign s_mcand[gi]  = mcand[gi-1];
            assign s_mplier[gi] = mplier[gi-1];
            assign s_func[gi]   = func[gi-1];
            assign s_tag[gi]    = tag[gi-1];
            assign s_bm[gi]     = bmask[gi-1];
        end
        assign n_acc[gi] = s_acc[gi] + s_mcand[gi] *
                           {{(PW-CW){1'b0}}, s_mplier[gi][CW-1:0]};
        assign n_mcand[gi]  = s_mcand[gi] << CW;
        assign n_mplier[gi] = s_mplier[gi] >> CW;
        assign n_v[gi]  = s_v[gi] & ~killed(s_bm[gi], res_bad, br_mask);
        assign n_bm[gi] = clr_mask(s_bm[gi], res_ok, br_mask);
    end

    // A squashed final entry never requests, so it cannot cause a stall
    assign done_valid = ~reset & v[L] & ~killed(bmask[L], res_bad, br_mask);
    assign stall      = done_valid & ~cdb_grant;
    assign fu_ready   = ~stall;

    always_comb begin
        done_result = '0;
        done_tag    = '0;
        done_bmask  = '0;
        if (!reset) begin
            done_result = (func[L] == 2'd0) ? acc[L][XLEN-1:0]
                                            : acc[L][PW-1:XLEN];
            done_tag    = tag[L];
            done_bmask  = bmask[L];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v <= '0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                acc[i]    <= '0;
                mcand[i]  <= '0;
                mplier[i] <= '0;
                func[i]   <= '0;
                tag[i]    <= '0;
                bmask[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (!stall) begin
                    v[i] <= n_v[i];
                    // Bubbles leave the payload of the last occupant in place
                    if (n_v[i]) begin
                        acc[i]    <= n_acc[i];
                        mcand[i]  <= n_mcand[i];
                        mplier[i] <= n_mplier[i];
                        func[i]   <= s_func[i];
                        tag[i]    <= s_tag[i];
                        bmask[i]  <= n_bm[i];
                    end else begin
                        bmask[i] <= clr_mask(bmask[i], res_ok, br_mask);
                    end
                end else begin
                    v[i]     <= v[i] & ~killed(bmask[i], res_bad, br_mask);
                    bmask[i] <= clr_mask(bmask[i], res_ok, br_mask);
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_fu.sv
// Directed bench for mult_fu: latency, function select, streaming,
// stall, branch resolve/squash and mid-flight reset.
module tb_mult_fu;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        is_valid = 1'b0;
    logic [31:0] is_opa = '0;
    logic [31:0] is_opb = '0;
    logic [1:0]  is_func = '0;
    logic [5:0]  is_dest_tag = '0;
    logic [3:0]  is_bmask = '0;
    logic        br_valid = 1'b0;
    logic [3:0]  br_mask = '0;
    logic        br_mispredict = 1'b0;
    logic        cdb_grant = 1'b1;
    logic        fu_ready;
    logic        done_valid;
    logic [31:0] done_result;
    logic [5:0]  done_tag;
    logic [3:0]  done_bmask;

    int n_cmp = 0;
    int n_bad = 0;

    mult_fu dut (
        .clock(clock),
        .reset(reset),
        .is_valid(is_valid),
        .is_opa(is_opa),
        .is_opb(is_opb),
        .is_func(is_func),
        .is_dest_tag(is_dest_tag),
        .is_bmask(is_bmask),
        .br_valid(br_valid),
        .br_mask(br_mask),
        .br_mispredict(br_mispredict),
        .cdb_grant(cdb_grant),
        .fu_ready(fu_ready),
        .done_valid(done_valid),
        .done_result(done_result),
        .done_tag(done_tag),
        .done_bmask(done_bmask)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] t,
                         input logic [3:0] m);
        is_valid    = 1'b1;
        is_func     = f;
        is_opa      = a;
        is_opb      = b;
        is_dest_tag = t;
        is_bmask    = m;
    endtask

    task automatic idle(input int n);
        is_valid      = 1'b0;
        br_valid      = 1'b0;
        br_mispredict = 1'b0;
        br_mask       = '0;
        cdb_grant     = 1'b1;
        repeat (n) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            if (k == 2) reset = 1'b0;
            @(negedge clock);
            n_cmp++;
            if (done_valid !== 1'b0 || fu_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_ctl k=%0d valid=%b ready=%b exp 0/1",
                         k, done_valid, fu_ready);
            end
            n_cmp++;
            if (done_result !== 32'd0 || done_tag !== 6'd0 ||
                done_bmask !== 4'd0) begin
                n_bad++;
                $display("FAIL reset_data k=%0d res=%h tag=%0d bm=%b exp 0",
                         k, done_result, done_tag, done_bmask);
            end
        end
    endtask

    task automatic test_mul_basic();
        idle(2);
        for (int k = 0; k < 6; k++) begin
            step();
            if (k == 0) drive(2'd0, 32'd7, 32'd6, 6'd5, 4'd0);
            else is_valid = 1'b0;
            @(negedge clock);
            n_cmp++;
            if (done_valid !== (k == 4)) begin
                n_bad++;
                $display("FAIL mul_valid k=%0d got %b exp %b",
                         k, done_valid, (k == 4));
            end
            if (k == 4) begin
                n_cmp++;
                if (done_result !== 32'd42 || done_tag !== 6'd5) begin
                    n_bad++;
                    $display("FAIL mul_data got %0d/%0d exp 42/5",
                             done_result, done_tag);
                end
            end
        end
    endtask

    task automatic test_funcs();
        logic [1:0]  fv [3] = '{2'd1, 2'd3, 2'd2};
        logic [31:0] av [3] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFF};
        logic [31:0] bv [3] = '{32'd2, 32'd2, 32'hFFFFFFFF};
        logic [31:0] ev [3] = '{32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF};
        for (int j = 0; j < 3; j++) begin
            idle(1);
            for (int k = 0; k < 5; k++) begin
                step();
                if (k == 0) drive(fv[j], av[j], bv[j], 6'(10 + j), 4'd0);
                else is_valid = 1'b0;
                @(negedge clock);
                if (k == 4) begin
                    n_cmp++;
                    if (done_valid !== 1'b1 || done_result !== ev[j] ||
                        done_tag !== 6'(10 + j)) begin
                        n_bad++;
                        $display("FAIL func%0d v=%b res=%h tag=%0d exp 1/%h/%0d",
                                 fv[j], done_valid, done_result, done_tag,
                                 ev[j], 10 + j);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        idle(2);
        for (int k = 0; k < 9; k++) begin
            step();
            if (k < 4) drive(2'd0, 32'(k + 1), 32'd3, 6'(k + 1), 4'd0);
            else is_valid = 1'b0;
            @(negedge clock);
            n_cmp++;
            if (done_valid !== (k >= 4 && k <= 7)) begin
                n_bad++;
                $display("FAIL b2b_valid k=%0d got %b", k, done_valid);
            end
            if (k >= 4 && k <= 7) begin
                n_cmp++;
                if (done_tag !== 6'(k - 3) || done_result !== 32'((k - 3) * 3)) begin
                    n_bad++;
                    $display("FAIL b2b_data k=%0d got %0d/%0d exp %0d/%0d",
                             k, done_tag, done_result, k - 3, (k - 3) * 3);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic       ev;
        logic [5:0] et;
        idle(2);
        for (int k = 0; k < 12; k++) begin
            step();
            cdb_grant = (k >= 7);
            if (k < 4) drive(2'd0, 32'(k + 1), 32'd5, 6'(k + 1), 4'd0);
            else is_valid = 1'b0;
            @(negedge clock);
            ev = (k >= 4 && k <= 10);
            et = (k <= 6) ? 6'd1 : 6'(k - 6);
            n_cmp++;
            if (done_valid !== ev || fu_ready !== !(k >= 4 && k <= 6)) begin
                n_bad++;
                $display("FAIL stall_ctl k=%0d v=%b rdy=%b exp %b/%b", k,
                         done_valid, fu_ready, ev, !(k >= 4 && k <= 6));
            end
            if (ev) begin
                n_cmp++;
                if (done_tag !== et || done_result !== 32'(et) * 32'd5) begin
                    n_bad++;
                    $display("FAIL stall_data k=%0d got %0d/%0d exp tag %0d",
                             k, done_tag, done_result, et);
                end
            end
        end
        idle(1);
    endtask

    task automatic test_branch();
        logic [3:0] ebm;
        // Mispredict of bit 0: only tag 2 survives
        idle(2);
        for (int k = 0; k < 8; k++) begin
            step();
            br_valid = 1'b0;
            br_mispredict = 1'b0;
            is_valid = 1'b0;
            if (k == 0) drive(2'd0, 32'd1, 32'd2, 6'd1, 4'b0001);
            if (k == 1) drive(2'd0, 32'd2, 32'd2, 6'd2, 4'b0010);
            if (k == 2) drive(2'd0, 32'd3, 32'd2, 6'd3, 4'b0001);
            if (k == 3) begin
                br_valid = 1'b1;
                br_mispredict = 1'b1;
                br_mask = 4'b0001;
            end
            @(negedge clock);
            n_cmp++;
            if (done_valid !== (k == 5)) begin
                n_bad++;
                $display("FAIL squash_valid k=%0d got %b", k, done_valid);
            end
            if (k == 5) begin
                n_cmp++;
                if (done_tag !== 6'd2 || done_result !== 32'd4 ||
                    done_bmask !== 4'b0010) begin
                    n_bad++;
                    $display("FAIL squash_data got %0d/%0d/%b exp 2/4/0010",
                             done_tag, done_result, done_bmask);
                end
            end
        end
        // Correct resolve of bit 1: all complete, tag 2 mask cleared
        idle(2);
        for (int k = 0; k < 8; k++) begin
            step();
            br_valid = 1'b0;
            br_mispredict = 1'b0;
            is_valid = 1'b0;
            if (k == 0) drive(2'd0, 32'd1, 32'd2, 6'd1, 4'b0001);
            if (k == 1) drive(2'd0, 32'd2, 32'd2, 6'd2, 4'b0010);
            if (k == 2) drive(2'd0, 32'd3, 32'd2, 6'd3, 4'b0001);
            if (k == 3) begin
                br_valid = 1'b1;
                br_mask = 4'b0010;
            end
            @(negedge clock);
            n_cmp++;
            if (done_valid !== (k >= 4 && k <= 6)) begin
                n_bad++;
                $display("FAIL resolve_valid k=%0d got %b", k, done_valid);
            end
            if (k >= 4 && k <= 6) begin
                ebm = (k == 5) ? 4'b0000 : 4'b0001;
                n_cmp++;
                if (done_tag !== 6'(k - 3) || done_bmask !== ebm ||
                    done_result !== 32'((k - 3) * 2)) begin
                    n_bad++;
                    $display("FAIL resolve_data k=%0d got %0d/%b exp %0d/%b",
                             k, done_tag, done_bmask, k - 3, ebm);
                end
            end
        end
        // Squash of a stalled final entry plus a killed incoming issue
        idle(2);
        for (int k = 0; k < 11; k++) begin
            step();
            cdb_grant = 1'b0;
            br_valid = 1'b0;
            br_mispredict = 1'b0;
            is_valid = 1'b0;
            if (k == 0) drive(2'd0, 32'd7, 32'd7, 6'd7, 4'b0100);
            if (k == 5) begin
                drive(2'd0, 32'd8, 32'd8, 6'd8, 4'b0100);
                br_valid = 1'b1;
                br_mispredict = 1'b1;
                br_mask = 4'b0100;
            end
            @(negedge clock);
            n_cmp++;
            if (done_valid !== (k == 4) || fu_ready !== (k != 4)) begin
                n_bad++;
                $display("FAIL kill_final k=%0d v=%b rdy=%b", k,
                         done_valid, fu_ready);
            end
        end
        idle(2);
    endtask

    task automatic test_reset_mid();
        idle(2);
        for (int k = 0; k < 15; k++) begin
            step();
            reset = (k == 3);
            is_valid = 1'b0;
            if (k < 3) drive(2'd0, 32'(k + 2), 32'd3, 6'(k + 1), 4'd0);
            if (k == 9) drive(2'd0, 32'd9, 32'd9, 6'd6, 4'd0);
            @(negedge clock);
            n_cmp++;
            if (done_valid !== (k == 13)) begin
                n_bad++;
                $display("FAIL rstmid_valid k=%0d got %b", k, done_valid);
            end
            if (k == 13) begin
                n_cmp++;
                if (done_result !== 32'd81 || done_tag !== 6'd6) begin
                    n_bad++;
                    $display("FAIL rstmid_data got %0d/%0d exp 81/6",
                             done_result, done_tag);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_funcs();
        test_back_to_back();
        test_stall();
        test_branch();
        test_reset_mid();
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
